// File: rtl/thermocouple_pkg.sv
// Frame layout and FSM encoding shared by the thermocouple SPI responder and the reader.
package thermocouple_pkg;

  localparam int FRAME_BITS = 32;
  localparam int TC_MSB     = 31;
  localparam int TC_LSB     = 18;
  localparam int FAULT_BIT  = 16;
  localparam int JT_MSB     = 15;
  localparam int JT_LSB     = 4;
  localparam int FLT_MSB    = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Bits 17 and 3 are reserved and always read as zero.
  function automatic logic [FRAME_BITS-1:0] pack_frame(
    input logic [13:0] tc,
    input logic [11:0] jt,
    input logic [3:0]  flt
  );
    logic [FRAME_BITS-1:0] w;
    w                   = '0;
    w[TC_MSB:TC_LSB]    = tc;
    w[FAULT_BIT]        = flt[3];
    w[JT_MSB:JT_LSB]    = jt;
    w[FLT_MSB:0]        = flt[2:0];
    return w;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizer for an asynchronous SPI pin with one history flop for edge pulses.
module spi_edge_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_hist;

  // Reset to the pin's idle level so releasing reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_hist <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_hist <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_hist;
  assign o_fall = ~r_sync & r_hist;

endmodule

// File: rtl/thermocouple_spi_responder.sv
// MAX31855-style responder: snapshots parallel temperature/fault words periodically and shifts them out on SPI.
module thermocouple_spi_responder
  import thermocouple_pkg::*;
#(
  parameter int CONV_CYCLES = 1200,
  parameter int CBITS       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_sclk,
  input  logic        i_cs_n,
  input  logic [13:0] i_tc_temp_in,
  input  logic [11:0] i_junction_temp_in,
  input  logic [3:0]  i_fault_in,
  output logic        o_miso,
  output logic        o_miso_oe,
  output logic        o_conv_done,
  output logic        o_frame_done
);

  localparam logic [CBITS-1:0] CONV_LAST = CBITS'(CONV_CYCLES - 1);
  localparam logic [5:0]       BIT_MAX   = 6'(FRAME_BITS);

  logic                  w_sclk_fall;
  logic                  w_sclk_rise_unused;
  logic                  w_cs_fall;
  logic                  w_cs_rise;
  logic [FRAME_BITS-1:0] w_frame;

  state_t                r_state;
  logic [FRAME_BITS-1:0] r_snapshot;
  logic [FRAME_BITS-1:0] r_shift;
  logic [5:0]            r_bit_cnt;
  logic [CBITS-1:0]      r_conv_cnt;
  logic                  r_miso;
  logic                  r_miso_oe;
  logic                  r_conv_done;
  logic                  r_frame_done;

  spi_edge_sync #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .i_async(i_sclk),
    .o_rise (w_sclk_rise_unused),
    .o_fall (w_sclk_fall)
  );

  spi_edge_sync #(.RST_VAL(1'b1)) u_cs_sync (
    .clk    (clk),
    .rst    (rst),
    .i_async(i_cs_n),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  assign w_frame = pack_frame(i_tc_temp_in, i_junction_temp_in, i_fault_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_snapshot   <= '0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_conv_cnt   <= '0;
      r_miso       <= 1'b0;
      r_miso_oe    <= 1'b0;
      r_conv_done  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_conv_done  <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // Frame start outranks a coincident conversion tick: the old snapshot is served.
          if (w_cs_fall) begin
            r_state    <= ACTIVE;
            r_shift    <= r_snapshot;
            r_miso     <= r_snapshot[FRAME_BITS-1];
            r_miso_oe  <= 1'b1;
            r_bit_cnt  <= '0;
            r_conv_cnt <= '0;
          end else if (r_conv_cnt == CONV_LAST) begin
            r_snapshot  <= w_frame;
            r_conv_done <= 1'b1;
            r_conv_cnt  <= '0;
          end else begin
            r_conv_cnt <= r_conv_cnt + 1'b1;
          end
        end
        ACTIVE: begin
          r_conv_cnt <= '0;
          // CS release wins over a same-cycle SCK fall.
          if (w_cs_rise) begin
            r_state      <= IDLE;
            r_miso       <= 1'b0;
            r_miso_oe    <= 1'b0;
            r_frame_done <= (r_bit_cnt == BIT_MAX);
          end else if (w_sclk_fall) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
            r_miso  <= r_shift[FRAME_BITS-2];
            if (r_bit_cnt != BIT_MAX) begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_miso       = r_miso;
  assign o_miso_oe    = r_miso_oe;
  assign o_conv_done  = r_conv_done;
  assign o_frame_done = r_frame_done;

endmodule
